audio_fader: RTL and testbench



---
 rtl/audio_fader_if.sv | 22 ++
 rtl/audio_fader.sv | 116 +++++++++++
 tb/tb_audio_fader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/audio_fader_if.sv
// Sample/strobe bundle between the tone path, the fader and the delta-sigma modulator.
interface audio_fader_if #(
    parameter int GAIN_W = 6
);
    logic              update;
    logic              mute;
    logic [11:0]       sample_in;
    logic [11:0]       sample_out;
    logic              out_valid;
    logic [GAIN_W:0]   gain;
    logic              active;

    modport master (
        output update, mute, sample_in,
        input  sample_out, out_valid, gain, active
    );

    modport slave (
        input  update, mute, sample_in,
        output sample_out, out_valid, gain, active
    );
endinterface

// File: rtl/audio_fader.sv
// Click-free ramped gain stage for the offset-binary sound path.
// Optional output limiter enabled by defining FADER_LIMITER_EN.
module audio_fader #(
    parameter int GAIN_W   = 6,
    parameter int RAMP_DIV = 4,
    parameter int LIMIT    = 1536
) (
    input logic          clk,
    input logic          rst_n,
    audio_fader_if.slave bus
);
    localparam int              DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RAMP_DIV - 1);
    localparam logic [GAIN_W:0]  UNITY   = (GAIN_W+1)'(1) << GAIN_W;

    if (RAMP_DIV < 1 || LIMIT < 0 || LIMIT > 2047) begin : g_bad_param
        $error("audio_fader: RAMP_DIV must be >= 1 and LIMIT within 0..2047");
    end

    typedef enum logic [1:0] {SILENT, ATTACK, OPEN, RELEASE} state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  div, div_n;
    logic [GAIN_W:0]   gain_r, gain_n;
    logic [11:0]       sample_r, sample_n;
    logic              valid_r, active_r;
    logic              wrap;

    assign wrap = (div == DIV_MAX);

    // Transitions never step the gain on the same strobe they are taken.
    always_comb begin
        state_n = state;
        div_n   = div;
        gain_n  = gain_r;
        case (state)
            SILENT: begin
                if (!bus.mute) begin
                    state_n = ATTACK;
                    div_n   = '0;
                end
            end
            ATTACK: begin
                if (bus.mute) begin
                    state_n = RELEASE;
                end else if (wrap) begin
                    div_n = '0;
                    if (gain_r != UNITY) gain_n = gain_r + 1'b1;
                    if (gain_n == UNITY) state_n = OPEN;
                end else begin
                    div_n = div + 1'b1;
                end
            end
            OPEN: begin
                if (bus.mute) begin
                    state_n = RELEASE;
                    div_n   = '0;
                end
            end
            RELEASE: begin
                if (!bus.mute) begin
                    state_n = ATTACK;
                end else if (wrap) begin
                    div_n = '0;
                    if (gain_r != '0) gain_n = gain_r - 1'b1;
                    if (gain_n == '0) state_n = SILENT;
                end else begin
                    div_n = div + 1'b1;
                end
            end
            default: state_n = SILENT;
        endcase
    end

    // Scale the signed deviation by the pre-step gain; >>> floors toward -inf.
    logic signed [12:0]        delta, dev;
    logic signed [GAIN_W+14:0] product;
    logic signed [13:0]        sum;

    always_comb begin
        delta   = $signed({1'b0, bus.sample_in}) - 13'sd2048;
        product = delta * $signed({1'b0, gain_r});
        dev     = 13'(product >>> GAIN_W);
`ifdef FADER_LIMITER_EN
        if (dev > $signed(13'(LIMIT)))       dev = $signed(13'(LIMIT));
        else if (dev < -$signed(13'(LIMIT))) dev = -$signed(13'(LIMIT));
`endif
        sum      = 14'(dev) + 14'sd2048;
        sample_n = sum[11:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SILENT;
            div      <= '0;
            gain_r   <= '0;
            sample_r <= 12'd2048;
            valid_r  <= 1'b0;
            active_r <= 1'b0;
        end else begin
            valid_r <= bus.update;
            if (bus.update) begin
                state    <= state_n;
                div      <= div_n;
                gain_r   <= gain_n;
                sample_r <= sample_n;
                active_r <= (state_n != SILENT);
            end
        end
    end

    assign bus.sample_out = sample_r;
    assign bus.out_valid  = valid_r;
    assign bus.gain       = gain_r;
    assign bus.active     = active_r;
endmodule

// File: tb/tb_audio_fader.sv
// Randomized check of audio_fader against a strobe-counting reference model.
module tb_audio_fader;
    localparam int GAIN_W   = 6;
    localparam int RAMP_DIV = 4;
    localparam int LIMIT    = 1536;
    localparam int UNITY    = 1 << GAIN_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    audio_fader_if #(.GAIN_W(GAIN_W)) bus ();

    audio_fader #(.GAIN_W(GAIN_W), .RAMP_DIV(RAMP_DIV), .LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: mode tracks the fade direction, cnt counts strobes spent ramping.
    typedef enum {M_QUIET, M_UP, M_FULL, M_DOWN} mode_t;
    mode_t m_mode;
    int    m_cnt, m_gain, m_out;

    task automatic model_reset();
        m_mode = M_QUIET; m_cnt = 0; m_gain = 0; m_out = 2048;
    endtask

    task automatic model_step(input logic m, input int s);
        int d;
        d = ((s - 2048) * m_gain) >>> GAIN_W;
`ifdef FADER_LIMITER_EN
        if (d > LIMIT) d = LIMIT;
        if (d < -LIMIT) d = -LIMIT;
`endif
        m_out = 2048 + d;
        case (m_mode)
            M_QUIET: if (!m) begin m_mode = M_UP; m_cnt = 0; end
            M_FULL:  if (m) begin m_mode = M_DOWN; m_cnt = 0; end
            M_UP: begin
                if (m) m_mode = M_DOWN;
                else begin
                    m_cnt++;
                    if (m_cnt == RAMP_DIV) begin
                        m_cnt = 0;
                        m_gain = (m_gain < UNITY) ? m_gain + 1 : UNITY;
                        if (m_gain == UNITY) m_mode = M_FULL;
                    end
                end
            end
            M_DOWN: begin
                if (!m) m_mode = M_UP;
                else begin
                    m_cnt++;
                    if (m_cnt == RAMP_DIV) begin
                        m_cnt = 0;
                        m_gain = (m_gain > 0) ? m_gain - 1 : 0;
                        if (m_gain == 0) m_mode = M_QUIET;
                    end
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One strobe, then a random number of idle cycles with out_valid low.
    task automatic strobe(input logic m, input logic [11:0] s);
        int idle;
        model_step(m, int'(s));
        @(negedge clk);
        bus.update = 1'b1; bus.mute = m; bus.sample_in = s;
        @(negedge clk);
        bus.update = 1'b0;
        bus.sample_in = 12'($urandom);
        chk("sample_out", int'(bus.sample_out), m_out);
        chk("out_valid", int'(bus.out_valid), 1);
        chk("gain", int'(bus.gain), m_gain);
        chk("active", int'(bus.active), int'(m_mode != M_QUIET));
        idle = $urandom_range(0, 2);
        if (idle > 0) begin
            repeat (idle) @(negedge clk);
            chk("valid_idle", int'(bus.out_valid), 0);
            chk("hold_out", int'(bus.sample_out), m_out);
        end
    endtask

    function automatic logic [11:0] rnd();
        return 12'($urandom);
    endfunction

    logic m;

    initial begin
        bus.update = 1'b0; bus.mute = 1'b0; bus.sample_in = 12'd2048;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out", int'(bus.sample_out), 2048);
        chk("rst_gain", int'(bus.gain), 0);
        chk("rst_active", int'(bus.active), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        rst_n = 1'b1;

        // Fade in: entry strobe plus 64 gain steps of RAMP_DIV strobes each.
        strobe(1'b0, 12'd4095);
        chk("first_out", int'(bus.sample_out), 2048);
        for (int i = 0; i < UNITY * RAMP_DIV; i++) strobe(1'b0, rnd());
        chk("open_gain", int'(bus.gain), UNITY);
        chk("open_active", int'(bus.active), 1);

        strobe(1'b0, 12'd4095);
`ifdef FADER_LIMITER_EN
        chk("open_max", int'(bus.sample_out), 3584);
        strobe(1'b0, 12'd0);
        chk("open_min", int'(bus.sample_out), 512);
        strobe(1'b0, 12'd3000);
        chk("open_mid", int'(bus.sample_out), 3000);
`else
        chk("open_max", int'(bus.sample_out), 4095);
        strobe(1'b0, 12'd0);
        chk("open_min", int'(bus.sample_out), 0);
`endif

        // Fade out to half gain; gain then holds 32 for the next RAMP_DIV strobes.
        for (int i = 0; i < 400 && !(m_gain == 32 && m_mode == M_DOWN); i++) strobe(1'b1, rnd());
        chk("half_gain", int'(bus.gain), 32);
        strobe(1'b1, 12'd3048);
        chk("half_3048", int'(bus.sample_out), 2548);
        strobe(1'b1, 12'd0);
        chk("half_0", int'(bus.sample_out), 1024);
        strobe(1'b1, 12'd2049);
        chk("half_2049", int'(bus.sample_out), 2048);

        for (int i = 0; i < 400 && m_mode != M_QUIET; i++) strobe(1'b1, rnd());
        chk("silent_gain", int'(bus.gain), 0);
        chk("silent_active", int'(bus.active), 0);
        strobe(1'b1, rnd());
        chk("silent_out", int'(bus.sample_out), 2048);

        // Back to full, then interrupt the release at gain 20.
        for (int i = 0; i < 400 && m_mode != M_FULL; i++) strobe(1'b0, rnd());
        chk("reopen_gain", int'(bus.gain), UNITY);
        for (int i = 0; i < 400 && m_gain != 20; i++) strobe(1'b1, rnd());
        chk("rel20_gain", int'(bus.gain), 20);
        strobe(1'b0, rnd());
        chk("reattack_gain", int'(bus.gain), 20);
        chk("reattack_active", int'(bus.active), 1);
        for (int i = 0; i < 20 && m_gain != 21; i++) strobe(1'b0, rnd());
        chk("reattack_up", int'(bus.gain), 21);

        // Random mute toggling with long stretches in each level.
        m = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 39) == 0) m = ~m;
            strobe(m, rnd());
        end

        // Asynchronous reset in the middle of an attack, between clock edges.
        for (int i = 0; i < 400 && m_mode != M_QUIET; i++) strobe(1'b1, rnd());
        for (int i = 0; i < 45; i++) strobe(1'b0, rnd());
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", int'(bus.sample_out), 2048);
        chk("arst_gain", int'(bus.gain), 0);
        chk("arst_active", int'(bus.active), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        strobe(1'b0, rnd());
        for (int i = 0; i < 30; i++) strobe(1'b0, rnd());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
